// File: rtl/dmem_burst_master_if.sv
// Command, stream and dmem-port signals of the burst master.
// master = burst master's view; slave = the environment's view.
interface dmem_burst_master_if #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned CNT_W = 8
);
    // Command
    logic             START;
    logic             DIR;
    logic [WIDTH-1:0] BASE;
    logic [CNT_W-1:0] LEN;
    logic             BUSY;
    logic             DONE;

    // Write stream (into dmem)
    logic             S_VALID;
    logic [WIDTH-1:0] S_DATA;
    logic             S_READY;

    // Read stream (out of dmem)
    logic             M_VALID;
    logic [WIDTH-1:0] M_DATA;
    logic             M_READY;

    // dmem port
    logic             MEM_WE;
    logic [WIDTH-1:0] MEM_A;
    logic [WIDTH-1:0] MEM_WD;
    logic [WIDTH-1:0] MEM_RD;

    modport master (
        input  START, DIR, BASE, LEN, S_VALID, S_DATA, M_READY, MEM_RD,
        output BUSY, DONE, S_READY, M_VALID, M_DATA, MEM_WE, MEM_A, MEM_WD
    );

    modport slave (
        output START, DIR, BASE, LEN, S_VALID, S_DATA, M_READY, MEM_RD,
        input  BUSY, DONE, S_READY, M_VALID, M_DATA, MEM_WE, MEM_A, MEM_WD
    );
endinterface

// File: rtl/dmem_burst_master.sv
// Burst initiator for the dmem port: moves LEN consecutive words between a
// write stream and dmem, or from dmem to a registered read stream.
module dmem_burst_master #(
    parameter int unsigned WIDTH  = 48,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned STRIDE = 4
) (
    input logic                  CLK,
    input logic                  RST,
    dmem_burst_master_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StDrain,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;

    logic             start_burst;
    logic             wr_hs;
    logic             rd_capture;
    logic             out_hs;
    logic             last_word;

    assign start_burst = (state_q == StIdle) && bus.START && (bus.LEN != '0);
    assign wr_hs       = (state_q == StWr) && bus.S_VALID && (rem_q != '0);
    // Output register may refill in the same cycle it is drained.
    assign rd_capture  = (state_q == StRd) && (rem_q != '0) && (!m_valid_q || bus.M_READY);
    assign out_hs      = m_valid_q && bus.M_READY;
    assign last_word   = (rem_q == CNT_W'(1));

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.START) begin
                    if (bus.LEN == '0) begin
                        state_d = StFin;
                    end else if (bus.DIR) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                if (wr_hs && last_word) begin
                    state_d = StFin;
                end
            end
            StRd: begin
                if (rd_capture && last_word) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_hs) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.BUSY    = 1'b0;
        bus.DONE    = 1'b0;
        bus.S_READY = 1'b0;
        bus.MEM_WE  = 1'b0;
        bus.MEM_A   = '0;
        bus.MEM_WD  = '0;
        unique case (state_q)
            StWr: begin
                bus.BUSY    = 1'b1;
                bus.S_READY = 1'b1;
                bus.MEM_WE  = bus.S_VALID;
                bus.MEM_A   = addr_q;
                bus.MEM_WD  = bus.S_DATA;
            end
            StRd: begin
                bus.BUSY  = 1'b1;
                bus.MEM_A = addr_q;
            end
            StDrain: begin
                bus.BUSY = 1'b1;
            end
            StFin: begin
                bus.DONE = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.M_VALID = m_valid_q;
    assign bus.M_DATA  = m_data_q;

    // Datapath next-state: address, remaining count, read-stream register
    always_comb begin
        addr_d    = addr_q;
        rem_d     = rem_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (start_burst) begin
            addr_d = bus.BASE & ~WIDTH'(3);
            rem_d  = bus.LEN;
        end

        if (wr_hs) begin
            addr_d = addr_q + WIDTH'(STRIDE);
            rem_d  = rem_q - CNT_W'(1);
        end

        if (rd_capture) begin
            m_data_d  = bus.MEM_RD;
            m_valid_d = 1'b1;
            addr_d    = addr_q + WIDTH'(STRIDE);
            rem_d     = rem_q - CNT_W'(1);
        end else if (out_hs && (state_q == StRd || state_q == StDrain)) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q    <= '0;
            rem_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Active states always have at least one word left to move.
    a_rem_nonzero: assert property (@(posedge CLK) disable iff (RST)
        (state_q == StWr || state_q == StRd) |-> (rem_q != '0));

    a_done_not_busy: assert property (@(posedge CLK) disable iff (RST)
        bus.DONE |-> !bus.BUSY);

    a_we_only_in_wr: assert property (@(posedge CLK) disable iff (RST)
        bus.MEM_WE |-> (state_q == StWr));

endmodule
